// File: rtl/mc_control_sequencer.sv
// mc_control_sequencer
//   Multi-cycle control sequencer: owns the control-unit state register and
//   steps IF -> ID -> EXE -> MEM -> WB, with wait states on instruction and
//   data memory, a global stall, a HALT state left via resume, and saturating
//   retire and cycle counters.
//
// Ports
//   CLK           in   rising-edge clock
//   RST           in   asynchronous active-low reset
//   Opcode        in   instruction opcode, stable from ID onward
//   stall         in   1 freezes the state (ignored in HALT)
//   imem_ready    in   instruction fetch done, qualifies leaving IF
//   dmem_ready    in   data access done, qualifies leaving MEM
//   resume        in   leave HALT (ignored elsewhere)
//   cur_state     out  registered state (IF=0 ID=1 EXE=2 WB=3 MEM=4 HALT=5)
//   n_state       out  combinational next state (not for use as a clock)
//   halted        out  1 while in HALT
//   instr_done    out  one-cycle pulse in the first cycle after a retire
//   retired_count out  instructions retired, saturating
//   cycle_count   out  non-halted cycles, saturating
module mc_control_sequencer #(
  parameter int                  OPCODE_W = 6,
  parameter int                  CNT_W    = 32,
  parameter logic [OPCODE_W-1:0] OP_SW    = 6'b110000,
  parameter logic [OPCODE_W-1:0] OP_LW    = 6'b110001,
  parameter logic [OPCODE_W-1:0] OP_BEQ   = 6'b110100,
  parameter logic [OPCODE_W-1:0] OP_BNE   = 6'b110101,
  parameter logic [OPCODE_W-1:0] OP_BGTZ  = 6'b110110,
  parameter logic [OPCODE_W-1:0] OP_J     = 6'b111000,
  parameter logic [OPCODE_W-1:0] OP_JR    = 6'b111001,
  parameter logic [OPCODE_W-1:0] OP_JAL   = 6'b111010,
  parameter logic [OPCODE_W-1:0] OP_HALT  = 6'b111111
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                stall,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                resume,
  output logic [2:0]          cur_state,
  output logic [2:0]          n_state,
  output logic                halted,
  output logic                instr_done,
  output logic [CNT_W-1:0]    retired_count,
  output logic [CNT_W-1:0]    cycle_count
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_WB   = 3'b011,
    S_MEM  = 3'b100,
    S_HALT = 3'b101
  } state_t;

  state_t           state_q, state_d;
  logic             advance;
  logic             retire;
  logic             instr_done_q;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] cycle_q;

  always_comb begin
    // stall overrides the memory handshakes; HALT ignores all of them
    advance = ~stall;
    case (state_q)
      S_IF:    if (!imem_ready) advance = 1'b0;
      S_MEM:   if (!dmem_ready) advance = 1'b0;
      default: ;
    endcase

    state_d = state_q;
    case (state_q)
      S_IF:  if (advance) state_d = S_ID;
      S_ID:
        if (advance) begin
          if (Opcode == OP_J || Opcode == OP_JR) state_d = S_IF;
          else if (Opcode == OP_HALT)            state_d = S_HALT;
          else if (Opcode == OP_JAL)             state_d = S_WB;
          else                                   state_d = S_EXE;
        end
      S_EXE:
        if (advance) begin
          if (Opcode == OP_BEQ || Opcode == OP_BNE || Opcode == OP_BGTZ) state_d = S_IF;
          else if (Opcode == OP_SW || Opcode == OP_LW)                   state_d = S_MEM;
          else                                                           state_d = S_WB;
        end
      S_MEM: if (advance) state_d = (Opcode == OP_SW) ? S_IF : S_WB;
      S_WB:  if (advance) state_d = S_IF;
      S_HALT: state_d = resume ? S_IF : S_HALT;
      default: state_d = S_IF;
    endcase

    retire = advance && (state_q != S_IF) && (state_q != S_HALT) &&
             ((state_d == S_IF) || (state_d == S_HALT));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IF;
      instr_done_q <= 1'b0;
      retired_q    <= '0;
      cycle_q      <= '0;
    end else begin
      state_q      <= state_d;
      instr_done_q <= retire;
      if (retire && !(&retired_q))
        retired_q <= retired_q + CNT_W'(1);
      if (state_q != S_HALT && !(&cycle_q))
        cycle_q <= cycle_q + CNT_W'(1);
    end
  end

  assign cur_state     = state_q;
  assign n_state       = state_d;
  assign halted        = (state_q == S_HALT);
  assign instr_done    = instr_done_q;
  assign retired_count = retired_q;
  assign cycle_count   = cycle_q;

endmodule

// File: doc/mc_control_sequencer.md
Name: mc_control_sequencer

Overview:
- Parametrised successor to the multi-cycle control unit's next-state logic. Holds the state register itself rather than only computing the next state.
- Adds wait-state handshakes for instruction and data memory, a global stall, a HALT state with resume, and instruction-retire and cycle counters.
- Sits in Control_unit. It drives cur_state to the control-signal decoder and the counters to the debug/perf interface.

Parameters:
- OPCODE_W, 6, opcode width.
- CNT_W, 32, width of retired_count and cycle_count (>=2).
- OP_SW, 6'b110000, store opcode.
- OP_LW, 6'b110001, load opcode.
- OP_BEQ / OP_BNE / OP_BGTZ, 6'b110100 / 6'b110101 / 6'b110110, branch opcodes.
- OP_J / OP_JR / OP_JAL, 6'b111000 / 6'b111001 / 6'b111010, jump opcodes.
- OP_HALT, 6'b111111, halt opcode.

Ports:
- CLK, input, 1, clock, rising edge.
- RST, input, 1, reset, asynchronous, active-low.
- Opcode, input, OPCODE_W, opcode of the instruction register, held stable by the datapath from ID onward.
- stall, input, 1, global stall; 1 freezes the state.
- imem_ready, input, 1, instruction fetch complete (qualifies IF).
- dmem_ready, input, 1, data access complete (qualifies MEM).
- resume, input, 1, leave HALT.
- cur_state, output, 3, registered current state.
- n_state, output, 3, combinational next state.
- halted, output, 1, 1 while cur_state==HALT.
- instr_done, output, 1, registered one-cycle retire pulse.
- retired_count, output, CNT_W, instructions retired, saturating.
- cycle_count, output, CNT_W, non-halted cycles, saturating.

Behaviour:
- State encodings: IF=000, ID=001, EXE=010, WB=011, MEM=100, HALT=101. 110 and 111 are illegal; n_state=IF from either.
- Reset (RST=0, asynchronous):
  - cur_state=IF.
  - instr_done=0, retired_count=0, cycle_count=0.
  - halted=0, since halted is derived from cur_state.
  - On release, the first rising edge evaluates from IF.
- advance: stall==0, and additionally imem_ready==1 in IF and dmem_ready==1 in MEM. If advance==0, n_state=cur_state.
- Transitions when advance==1:
  - IF -> ID.
  - ID -> IF for J or JR; -> HALT for HALT; -> WB for JAL; -> EXE for all others. Unlisted opcodes are treated as ALU ops.
  - EXE -> IF for BEQ, BNE or BGTZ; -> MEM for SW or LW; -> WB otherwise.
  - MEM -> IF for SW; -> WB otherwise.
  - WB -> IF.
- HALT:
  - n_state=IF when resume==1, otherwise HALT.
  - stall, imem_ready and dmem_ready are ignored in HALT.
  - resume is ignored in every other state.
- cur_state<=n_state on every rising edge.
- Retire event: advance==1, cur_state not in {IF, HALT}, and n_state is IF or HALT.
  - On the edge that takes this transition, instr_done<=1; otherwise instr_done<=0.
  - On the same edge, retired_count increments unless it is all-ones.
  - Result: instr_done is high for exactly the first cycle of the following IF or HALT.
- cycle_count increments on every edge where cur_state!=HALT, unless it is all-ones. Stalled and wait cycles count.
- Counters saturate, never wrap.
- Simultaneous events:
  - stall has priority over ready signals: no advance and no retire while stall==1.
  - Reset asserted mid-instruction (any state, including HALT or a memory wait) aborts immediately. The partial instruction is not counted.
- n_state is purely combinational from cur_state, Opcode, stall, imem_ready, dmem_ready and resume. It is glitch-tolerant and must not be used as a clock.

Test Plan:
- Reset release with imem_ready=dmem_ready=1, stall=0, Opcode=6'b000000 (add) -> cur_state 000,001,010,011,000. instr_done=1 only in the 5th cycle. retired_count=1; cycle_count=4 at that point.
- Opcode=OP_LW, dmem_ready=0 for 3 cycles in MEM -> MEM held 4 cycles total, then WB, IF. retired_count +1. cycle_count includes the 3 wait cycles.
- Opcode=OP_HALT:
  - Expected path: IF, ID, HALT; halted=1 and instr_done=1 in the first HALT cycle; cycle_count frozen for 10 cycles.
  - Checks in HALT: stall=1 ignored. resume=1 -> IF next cycle with halted=0.
  - Check outside HALT: resume=1 pulsed in EXE has no effect.
- Opcode=OP_BEQ with stall=1 asserted in EXE for 2 cycles while imem_ready toggles -> EXE held 3 cycles, then IF. Exactly one retire pulse.
- RST driven low asynchronously mid-MEM of SW, between clock edges -> cur_state=IF and counters=0 immediately, with no clock edge needed. After release, the next instruction runs normally.
- CNT_W=4, 20 back-to-back J instructions -> retired_count saturates at 4'hF, cycle_count saturates at 4'hF, instr_done still pulses per retire.
